// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// master: execute stage (drives Start/Funct/operands, observes HI/LO/Busy/Done).
// slave : muldiv_unit (samples the request, owns HI/LO, drives Busy/Done).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [5:0]      Funct;
    logic [XLEN-1:0] Rdata1;
    logic [XLEN-1:0] Rdata2;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;
    logic            Busy;
    logic            Done;

    modport master (
        output Start, Funct, Rdata1, Rdata2,
        input  HI, LO, Busy, Done
    );

    modport slave (
        input  Start, Funct, Rdata1, Rdata2,
        output HI, LO, Busy, Done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU responder owning HI/LO; MTHI/MTLO write HI/LO directly.
// Latency: mult/div result on HI/LO 33 cycles after the accepted Start edge (17 for
//   short multipliers when MULDIV_EARLY_OUT_EN is defined); MTHI/MTLO land at the Start edge.
// Backpressure: Busy is high outside IDLE and every Start seen then is dropped; the
//   requester must hold and re-issue. Start in the Done cycle is accepted.
// Ports: CLK, RST (async active-low), bus (slave modport: Start, Funct, Rdata1, Rdata2 in;
//   HI, LO, Busy, Done out).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          CLK,
    input  logic          RST,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    // Mult: {partial product, remaining multiplier}. Div: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opd_q, opd_d;       // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d; // product / quotient sign
    logic                neg_hi_q, neg_hi_d; // remainder sign
    logic                dz_q, dz_d;         // divide by zero
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic                early_q, early_d;   // multiplier magnitude fits in the low half
`endif

    // Operand magnitudes for the request currently on the bus.
    logic            op_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign op_signed = (bus.Funct == F_MULT) || (bus.Funct == F_DIV);
    assign a_neg     = op_signed & bus.Rdata1[XLEN-1];
    assign b_neg     = op_signed & bus.Rdata2[XLEN-1];
    assign a_mag     = a_neg ? -bus.Rdata1 : bus.Rdata1;
    assign b_mag     = b_neg ? -bus.Rdata2 : bus.Rdata2;

    // Shift-add step: 33-bit sum keeps the carry that moves into the top bit.
    logic [XLEN:0] mul_sum;
    assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q})
                              : {1'b0, acc_q[2*XLEN-1:XLEN]};

    // Restoring step: remainder shifted left with the next dividend bit appended.
    logic [XLEN:0]   div_rem;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
    assign q_bit    = (div_rem >= {1'b0, opd_q});
    assign rem_next = q_bit ? XLEN'(div_rem - {1'b0, opd_q}) : div_rem[XLEN-1:0];

    logic last_iter;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt_q == CW'(XLEN-1)) || (early_q && (cnt_q == CW'(XLEN/2-1)));
    // Early exit leaves the product sitting half a word too high.
    assign prod_mag  = early_q ? (acc_q >> (XLEN/2)) : acc_q;
`else
    assign last_iter = (cnt_q == CW'(XLEN-1));
    assign prod_mag  = acc_q;
`endif
    assign prod_fix = neg_lo_q ? -prod_mag : prod_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        early_d  = early_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.Funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            // Funct[1] separates divides from multiplies.
                            is_div_d = bus.Funct[1];
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                            dz_d     = (bus.Rdata2 == '0);
                            opd_d    = bus.Funct[1] ? b_mag : a_mag;
                            acc_d    = {{XLEN{1'b0}}, (bus.Funct[1] ? a_mag : b_mag)};
                            cnt_d    = '0;
`ifdef MULDIV_EARLY_OUT_EN
                            early_d  = ~bus.Funct[1] && (b_mag[XLEN-1:XLEN/2] == '0);
`endif
                            state_d  = S_CALC;
                        end
                        F_MTHI:  hi_d = bus.Rdata1;
                        F_MTLO:  lo_d = bus.Rdata1;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = {rem_next, acc_q[XLEN-2:0], q_bit};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor yields all-ones quotient and the dividend as
                    // remainder; the remainder sign fix restores the original Rdata1.
                    lo_d = dz_q ? '1
                                : (neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
                    hi_d = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            early_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
            early_q  <= early_d;
`endif
        end
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.Busy = (state_q != S_IDLE);
    assign bus.Done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    muldiv_unit_if bus ();
    muldiv_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of one request, from plain integer arithmetic.
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        logic [63:0] r;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = hi_m;
        l = lo_m;
        case (f)
            6'h18: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            6'h19: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
            6'h1A: begin
                if (b == 0) begin l = '1; h = a; end
                else begin p = sa / sb; r = sa % sb; l = p[31:0]; h = r[31:0]; end
            end
            6'h1B: begin
                if (b == 0) begin l = '1; h = a; end
                else begin l = a / b; h = a % b; end
            end
            6'h11: h = a;
            6'h13: l = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
        logic [31:0] mag;
        mag = (f == 6'h18 && b[31]) ? -b : b;
        exp_lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
        if ((f == 6'h18 || f == 6'h19) && mag < 32'h10000) exp_lat = 17;
`endif
    endfunction

    function automatic bit is_md(input logic [5:0] f);
        return f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B;
    endfunction

    // Drive a request and return #1 after the edge that samples it.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.Start  = 1'b1;
        bus.Funct  = f;
        bus.Rdata1 = a;
        bus.Rdata2 = b;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
    endtask

    // c0 = cycles already elapsed since the start edge.
    task automatic wait_done(input string tag, input int lat, input int c0,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        int done_at;
        done_at = -1;
        for (int c = c0 + 1; c <= lat + 8 && done_at < 0; c++) begin
            @(posedge CLK);
            #1;
            if (bus.Done === 1'b1) done_at = c;
            else if (c == lat - 1) begin
                chk({tag, " hold"}, {bus.HI, bus.LO}, {old_hi, old_lo});
                chk({tag, " busy"}, 64'(bus.Busy), 64'd1);
            end
        end
        chk({tag, " latency"}, 64'(done_at), 64'(lat));
        chk({tag, " idle"}, 64'(bus.Busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        ref_op(f, a, b, eh, el);
        start_op(f, a, b);
        if (is_md(f)) begin
            chk({tag, " busy0"}, {62'd0, bus.Busy, bus.Done}, 64'd2);
            wait_done(tag, exp_lat(f, b), 0, hi_m, lo_m);
        end else begin
            chk({tag, " nobusy"}, {62'd0, bus.Busy, bus.Done}, 64'd0);
        end
        chk({tag, " hilo"}, {bus.HI, bus.LO}, {eh, el});
        hi_m = eh;
        lo_m = el;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [5:0]  df [13] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1B, 6'h1A, 6'h11, 6'h13, 6'h10,
                             6'h19, 6'h18, 6'h19, 6'h1A};
    logic [31:0] da [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd7,
                             32'h80000000, 32'h12345678, 32'h9ABCDEF0, 32'hDEAD, 32'd3, 32'd7,
                             32'd1, 32'hFFFFFFF9};
    logic [31:0] db [13] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0,
                             32'd0, 32'd5, 32'hFFFFFFFE, 32'h00010000, 32'd0};
    logic [63:0] dx [13] = '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE,
                             64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                             64'h00000007_FFFFFFFF, 64'h00000000_80000000,
                             64'h12345678_80000000, 64'h12345678_9ABCDEF0,
                             64'h12345678_9ABCDEF0, 64'h00000000_0000000F,
                             64'hFFFFFFFF_FFFFFFF2, 64'h00000000_00010000,
                             64'hFFFFFFF9_FFFFFFFF};
    logic [5:0]  fl [6] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13};

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        bus.Start  = 1'b0;
        bus.Funct  = '0;
        bus.Rdata1 = '0;
        bus.Rdata2 = '0;
        #2;
        chk("reset outputs", {bus.HI, bus.LO}, 64'd0);
        chk("reset flags", {62'd0, bus.Busy, bus.Done}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("dir%0d", i), df[i], da[i], db[i]);
            chk($sformatf("dir%0d const", i), {bus.HI, bus.LO}, dx[i]);
        end

        // Requests while busy are dropped, MTLO included.
        start_op(6'h1A, 32'd100, 32'd7);
        bus.Start = 1'b1; bus.Funct = 6'h13; bus.Rdata1 = 32'hAAAA; bus.Rdata2 = 32'd0;
        @(posedge CLK); #1;
        bus.Funct = 6'h18; bus.Rdata1 = 32'd3; bus.Rdata2 = 32'd5;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        wait_done("busy ignore", 33, 2, hi_m, lo_m);
        chk("busy ignore hilo", {bus.HI, bus.LO}, 64'h00000002_0000000E);
        hi_m = 32'd2;
        lo_m = 32'd14;

        // Reset in the middle of a multiply.
        start_op(6'h18, 32'h1234, 32'h5678);
        repeat (9) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("midrst hilo", {bus.HI, bus.LO}, 64'd0);
        chk("midrst flags", {62'd0, bus.Busy, bus.Done}, 64'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst no done", 64'(bus.Done), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        hi_m = '0;
        lo_m = '0;
        @(negedge CLK);
        run_op("post rst", 6'h18, 32'd3, 32'd5);
        chk("post rst const", {bus.HI, bus.LO}, 64'h0000000F);

        // Randomized back-to-back traffic, each request issued in the prior Done cycle.
        for (int i = 0; i < 40; i++) begin
            f = fl[$urandom_range(0, 5)];
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(0, 65535);
                2:       b = -$urandom_range(1, 65535);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d f=%h a=%h b=%h", i, f, a, b), f, a, b);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
